spi_responder: RTL and testbench

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_responder.sv | 177 +++++++++++++++++
 tb/tb_spi_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP,
    PUSH
  } spi_state_e;

  localparam int         SPI_FRAME_BITS = 24;
  localparam int         SPI_RESP_BITS  = 8;
  localparam logic [7:0] SPI_FILL_BYTE  = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: shifts in a frame, returns a response byte during the
// trailing bits, and pushes the completed frame into a receive FIFO.
//
// state | meaning
// IDLE  | waiting for chip select to fall
// SHIFT | receiving leading bits, miso held low
// RESP  | receiving trailing bits while shifting out the response byte
// PUSH  | one cycle: write frame to RX FIFO, pulse frame_done
module spi_responder
  import spi_pkg::*;
#(
  parameter int                   FRAME_BITS = SPI_FRAME_BITS,
  parameter int                   RESP_BITS  = SPI_RESP_BITS,
  parameter logic [RESP_BITS-1:0] FILL_BYTE  = RESP_BITS'(SPI_FILL_BYTE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  rx_full,
  output logic                  rx_wr_en,
  output logic [FRAME_BITS-1:0] rx_din,
  input  logic                  tx_empty,
  output logic                  tx_rd_en,
  input  logic [RESP_BITS-1:0]  tx_dout,
  output logic                  frame_done,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_RESP_LAST = CNT_W'(FRAME_BITS - RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_meta_q;
  logic mosi_sync_q;

  spi_state_e             state_q;
  spi_state_e             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [RESP_BITS-1:0]   resp_q;
  logic                   miso_q;

  logic shift_en;
  logic resp_load;
  logic miso_shift;
  logic abort;
  logic set_underrun;
  logic set_overflow;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clock    (clock),
    .reset    (reset),
    .async_in (sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clock    (clock),
    .reset    (reset),
    .async_in (cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi shares the sclk synchronizer depth so it lines up with sclk_rise
  always_ff @(posedge clock) begin
    if (reset) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_en     = 1'b0;
    resp_load    = 1'b0;
    miso_shift   = 1'b0;
    abort        = 1'b0;
    set_underrun = 1'b0;
    set_overflow = 1'b0;
    tx_rd_en     = 1'b0;
    rx_wr_en     = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (cnt_q == CNT_RESP_LAST) begin
            state_d   = RESP;
            resp_load = 1'b1;
            if (!tx_empty) tx_rd_en = 1'b1;
            else set_underrun = 1'b1;
          end
        end
      end
      RESP: begin
        if (cs_rise) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          miso_shift = sclk_fall;
          if (sclk_rise) begin
            shift_en = 1'b1;
            if (cnt_q == CNT_FRAME_LAST) state_d = PUSH;
          end
        end
      end
      PUSH: begin
        frame_done = 1'b1;
        if (!rx_full) rx_wr_en = 1'b1;
        else set_overflow = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      resp_q      <= '0;
      miso_q      <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      if (state_q == IDLE && cs_fall) cnt_q <= '0;
      else if (shift_en && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;

      if (shift_en) shift_q <= {shift_q[FRAME_BITS-2:0], mosi_sync_q};

      if (abort) resp_q <= '0;
      else if (resp_load) resp_q <= tx_empty ? FILL_BYTE : tx_dout;
      else if (miso_shift) resp_q <= resp_q << 1;

      if (miso_shift) miso_q <= resp_q[RESP_BITS-1];
      else if (state_d != RESP) miso_q <= 1'b0;

      if (set_overflow) rx_overflow <= 1'b1;
      if (set_underrun) tx_underrun <= 1'b1;
      if (abort) frame_abort <= 1'b1;
    end
  end

  assign miso   = miso_q;
  assign rx_din = shift_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: an SPI initiator task drives frames while
// a frame-level model predicts pushes, pops, response bytes and sticky flags.
module tb_spi_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk, cs_n, mosi, miso;
  logic        rx_full, rx_wr_en, tx_empty, tx_rd_en;
  logic [23:0] rx_din;
  logic [7:0]  tx_dout;
  logic        frame_done, rx_overflow, tx_underrun, frame_abort;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  int   exp_pushes = 0, exp_pops = 0, exp_done = 0;
  logic exp_ovf = 1'b0, exp_unr = 1'b0, exp_abt = 1'b0;
  int   act_pushes = 0, act_pops = 0, act_done = 0;
  logic [23:0] last_rx = '0;
  logic [7:0]  got_resp = '0;
  time  t_last_rise = 0;

  logic [23:0] b2b_frames [4] = '{24'h010203, 24'hFEDCBA, 24'h800001, 24'h7F7F7F};
  logic [7:0]  b2b_bytes  [4] = '{8'h81, 8'h42, 8'h00, 8'hC3};

  spi_responder dut (
    .clock       (clock),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .rx_full     (rx_full),
    .rx_wr_en    (rx_wr_en),
    .rx_din      (rx_din),
    .tx_empty    (tx_empty),
    .tx_rd_en    (tx_rd_en),
    .tx_dout     (tx_dout),
    .frame_done  (frame_done),
    .rx_overflow (rx_overflow),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every push must match the model queue and follow the 24th rise by 2 sync + 1 cycles.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_wr_en) begin
        act_pushes++;
        last_rx = rx_din;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL push_unexpected: got rx_din %0h expected no push", rx_din);
        end else begin
          chk("rx_din", 32'(rx_din), 32'(exp_q.pop_front()));
        end
        chk("push_latency", 32'($time - t_last_rise), 32'd30);
        chk("push_with_done", 32'(frame_done), 32'd1);
      end
      if (tx_rd_en) act_pops++;
      if (frame_done) act_done++;
    end
  end

  task automatic send_frame(input logic [23:0] data, input int nbits, input bit raise_cs, input int gap);
    logic [7:0] resp;
    resp = tx_empty ? 8'hFF : tx_dout;
    if (nbits >= 16) begin
      if (tx_empty) exp_unr = 1'b1;
      else exp_pops++;
    end
    if (raise_cs) begin
      if (nbits == 24) begin
        exp_done++;
        if (rx_full) exp_ovf = 1'b1;
        else begin
          exp_pushes++;
          exp_q.push_back(data);
        end
      end else begin
        exp_abt = 1'b1;
      end
    end
    got_resp = '0;
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[23-i];
      #50;
      if (i >= 16) begin
        chk("miso_resp", 32'(miso), 32'(resp[23-i]));
        got_resp = {got_resp[6:0], miso};
      end else begin
        chk("miso_zero", 32'(miso), 32'd0);
      end
      sclk = 1'b1;
      t_last_rise = $time;
      #50;
      sclk = 1'b0;
    end
    if (raise_cs) begin
      #50;
      cs_n = 1'b1;
      mosi = 1'b0;
      #(gap);
    end
  endtask

  task automatic check_state(input string tag);
    #200;
    chk({tag, "_pushes"}, 32'(act_pushes), 32'(exp_pushes));
    chk({tag, "_pops"}, 32'(act_pops), 32'(exp_pops));
    chk({tag, "_done"}, 32'(act_done), 32'(exp_done));
    chk({tag, "_overflow"}, 32'(rx_overflow), 32'(exp_ovf));
    chk({tag, "_underrun"}, 32'(tx_underrun), 32'(exp_unr));
    chk({tag, "_abort"}, 32'(frame_abort), 32'(exp_abt));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_miso_idle"}, 32'(miso), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_wr_en"}, 32'(rx_wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(tx_rd_en), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_overflow"}, 32'(rx_overflow), 32'd0);
    chk({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
    chk({tag, "_abort"}, 32'(frame_abort), 32'd0);
    chk({tag, "_rx_din"}, 32'(rx_din), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    rx_full = 1'b0; tx_empty = 1'b1; tx_dout = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Nominal frame with a response byte
    tx_empty = 1'b0; tx_dout = 8'h5A;
    send_frame(24'hA5C33C, 24, 1'b1, 100);
    check_state("nominal");
    chk("nominal_rx_literal", 32'(last_rx), 32'hA5C33C);
    chk("nominal_resp_literal", 32'(got_resp), 32'h5A);
    chk("nominal_pushes_literal", 32'(act_pushes), 32'd1);
    chk("nominal_pops_literal", 32'(act_pops), 32'd1);

    // TX FIFO empty: fill byte, underrun, frame still pushed
    tx_empty = 1'b1; tx_dout = 8'h00;
    send_frame(24'h000000, 24, 1'b1, 100);
    check_state("underrun");
    chk("underrun_resp_literal", 32'(got_resp), 32'hFF);
    chk("underrun_flag_literal", 32'(tx_underrun), 32'd1);
    chk("underrun_pushes_literal", 32'(act_pushes), 32'd2);

    // RX FIFO full: no write, overflow, frame_done still pulses
    tx_empty = 1'b0; tx_dout = 8'h96; rx_full = 1'b1;
    send_frame(24'h123456, 24, 1'b1, 100);
    rx_full = 1'b0;
    check_state("overflow");
    chk("overflow_flag_literal", 32'(rx_overflow), 32'd1);
    chk("overflow_done_literal", 32'(act_done), 32'd3);
    chk("overflow_pushes_literal", 32'(act_pushes), 32'd2);

    // Abort after 10 edges, then a full frame
    tx_dout = 8'h3C;
    send_frame(24'hABCDEF, 10, 1'b1, 100);
    send_frame(24'hFFFFFF, 24, 1'b1, 100);
    check_state("abort");
    chk("abort_flag_literal", 32'(frame_abort), 32'd1);
    chk("abort_rx_literal", 32'(last_rx), 32'hFFFFFF);
    chk("abort_pops_literal", 32'(act_pops), 32'd3);

    // Reset after 20 edges with an empty TX FIFO
    tx_empty = 1'b1; tx_dout = 8'hC7;
    send_frame(24'h5A5A5A, 20, 1'b0, 0);
    @(negedge clock);
    reset = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    @(negedge clock);
    check_all_zero("midreset");
    exp_ovf = 1'b0; exp_unr = 1'b0; exp_abt = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_state("midreset");
    chk("midreset_pushes_literal", 32'(act_pushes), 32'd3);

    // Four back-to-back frames, 2 idle cycles between cs_n rise and fall
    tx_empty = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx_dout = b2b_bytes[k];
      send_frame(b2b_frames[k], 24, 1'b1, 20);
      chk("b2b_resp", 32'(got_resp), 32'(b2b_bytes[k]));
    end
    check_state("b2b");
    chk("b2b_pushes_literal", 32'(act_pushes), 32'd7);
    chk("b2b_last_literal", 32'(last_rx), 32'h7F7F7F);
    chk("b2b_flags_literal", 32'({rx_overflow, tx_underrun, frame_abort}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
